// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two DMEM requesters, the arbiter and the single-port DMEM.
// The arbiter uses the slave modport. The requesters and DMEM side uses the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dataW;
    logic              mem_MemRW;
    logic [DATA_W-1:0] mem_dataR;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_dataR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_dataW, mem_MemRW
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_dataR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_dataW, mem_MemRW
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer that shares a single-port DMEM between two requesters.
// Each accepted request becomes one DMEM cycle (ACCESS). A one-cycle response pulse follows it.
// Optional macro DMEM_ARB_MISALIGN_CHECK_EN blocks requests with addr[1:0] != 0 and flags them with rsp_err.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              winner;
    logic              grant_en;
    logic              issue_ok;
    logic [1:0]        ready;
    logic              mem_we;

    // Pick the winner: the only valid requester, or on a tie the one not served last.
    always_comb begin
        winner = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            winner = ~last_grant;
        end
    end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    // A latched request is issued to DMEM only when it is word-aligned.
    always_comb begin
        issue_ok = (lat_addr[1:0] == 2'b00);
    end
`else
    // Without the check every latched request is issued unchanged.
    always_comb begin
        issue_ok = 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, grant handshake and DMEM write strobe.
    // ready is gated with rst_n so that no grant is seen while reset is held.
    always_comb begin
        state_nxt = state;
        ready     = '0;
        mem_we    = 1'b0;
        grant_en  = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (bus.req_valid != 2'b00)) begin
                    grant_en      = 1'b1;
                    ready[winner] = 1'b1;
                    state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                mem_we    = lat_we & issue_ok;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request, update the round-robin pointer and produce the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            lat_id      <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (grant_en) begin
                last_grant <= winner;
                lat_id     <= winner;
                lat_we     <= bus.req_we[winner];
                lat_addr   <= winner ? bus.req_addr1  : bus.req_addr0;
                lat_wdata  <= winner ? bus.req_wdata1 : bus.req_wdata0;
            end
            if (state == ACCESS) begin
                rsp_valid_q[lat_id] <= 1'b1;
                rsp_rdata_q         <= (lat_we || !issue_ok) ? '0 : bus.mem_dataR;
                rsp_err_q           <= ~issue_ok;
            end
        end
    end

    // mem_addr and mem_dataW follow the latched request. They hold until the next grant.
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_dataW = lat_wdata;
    assign bus.mem_MemRW = mem_we;
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port DMEM (addr / dataW / dataR / MemRW, write on rising clk, combinational read).
- Shares DMEM between requester 0 (core load/store path) and requester 1 (debug/DMA loader) using round-robin arbitration.
- Each request is latched and issued as exactly one clean DMEM cycle, then answered with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_we  in  2  per-requester write enable, 1 = write, 0 = read.
- req_addr0  in  ADDR_W  requester 0 byte address.
- req_addr1  in  ADDR_W  requester 1 byte address.
- req_wdata0  in  DATA_W  requester 0 write data.
- req_wdata1  in  DATA_W  requester 1 write data.
- rsp_valid  out  2  per-requester response pulse.
- rsp_rdata  out  DATA_W  read data, shared, qualified by rsp_valid.
- rsp_err  out  1  misaligned-access flag, qualified by rsp_valid.
- mem_addr  out  ADDR_W  to DMEM addr.
- mem_dataW  out  DATA_W  to DMEM dataW.
- mem_MemRW  out  1  to DMEM MemRW, 1 = write.
- mem_dataR  in  DATA_W  from DMEM dataR.

Behaviour:
- Reset (async assert, sync release): state = IDLE; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; mem_addr = 0; mem_dataW = 0; mem_MemRW = 0; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE and ACCESS.
- IDLE, no req_valid bit set: stay in IDLE; mem_MemRW = 0.
- IDLE, any req_valid bit set:
  - Winner: the only valid requester, or on a tie the requester != last_grant.
  - Assert req_ready[winner] combinationally in this cycle. Handshake = valid & ready; the requester may drop valid or present a new request after this edge.
  - At the edge, latch winner id, we, addr and wdata; set last_grant = winner; go to ACCESS.
- ACCESS (always exactly 1 cycle):
  - mem_addr / mem_dataW are driven from the latched request; mem_MemRW = latched we. DMEM commits the write on the edge that ends ACCESS.
  - For reads, capture mem_dataR into rsp_rdata at the end of ACCESS; for writes, rsp_rdata = 0.
  - req_ready = 0 throughout ACCESS. Go to IDLE.
- Response: in the cycle after ACCESS, rsp_valid[winner] = 1 for exactly one cycle, for both reads and writes (write ack). rsp_rdata and rsp_err hold their value until the next response.
- Latency: request accepted at edge N; memory access in cycle N+1; response visible in cycle N+2. Peak throughput is one access per 2 cycles.
- Acceptance can coincide with a response: in IDLE, the next request may be accepted in the same cycle rsp_valid pulses.
- Outside ACCESS, mem_MemRW = 0 and mem_addr / mem_dataW hold their last values (no spurious writes).
- A valid held by the losing requester is kept pending. Round-robin guarantees it wins the next arbitration, so maximum wait is one transaction.
- Reset asserted mid-ACCESS: mem_MemRW drops to 0 immediately (asynchronously); the write may or may not commit; no response is issued.
- Address passes through unmodified. Word alignment is the requester's responsibility unless the optional feature is enabled.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_CHECK_EN.
- Defined:
  - A latched request with addr[1:0] != 0 is not issued; mem_MemRW stays 0 during its ACCESS cycle.
  - Its response pulses on the normal timing with rsp_err = 1 and rsp_rdata = 0.
  - Aligned requests respond with rsp_err = 0.
- Undefined: rsp_err is tied to 0; all addresses go to DMEM unchanged.

Test Plan:
- Write then read: req0 write addr 0x4, data 0xA5A5A5A5 -> mem_MemRW = 1 for exactly one cycle, rsp_valid[0] pulses 2 cycles after accept. Then req0 read 0x4 -> rsp_rdata = 0xA5A5A5A5.
- Tie: both valid in the first cycle after reset (req0 write 0x8 = 0x00FFFFFF, req1 read 0x8) -> req0 is granted first; req1 is granted in the next IDLE and reads 0x00FFFFFF.
- Sustained contention: both hold valid for 8 transactions -> grants alternate 0,1,0,1…; each requester completes 4; no cycle has req_ready = 2'b11.
- Back-to-back: req1 reads 0x0, 0x4, 0xC with valid held high -> accepts every 2 cycles; responses in order; the unwritten 0xC returns the DMEM's uninitialised value, with no X on rsp_valid.
- Reset mid-ACCESS of a write to 0x10 -> mem_MemRW = 0 and rsp_valid = 0 immediately; after release, state = IDLE and req0 is granted first on a tie.
- With DMEM_ARB_MISALIGN_CHECK_EN: req0 write 0x6 -> mem_MemRW never asserted, rsp_err = 1, rsp_rdata = 0. Read of aligned 0x4 -> rsp_err = 0.
